// File: rtl/core_pkg.sv
// Shared core typedefs: memory-port arbiter state, owner encoding and the
// DRAM request bundle latched at grant time.
package core_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = WORD_W / 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BE_W-1:0]   be_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        OWNER_IF,
        OWNER_LSU
    } mem_owner_e;

    typedef struct packed {
        logic  we;
        be_t   be;
        word_t addr;
        word_t wdata;
    } dram_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto a single DRAM
// port with one transaction outstanding, IF starvation guard, flush squash and timeout.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_en,
    input  logic              flush_en_ip,
    input  logic              if_req_ip,
    input  logic [WORD_W-1:0] if_addr_ip,
    output logic              if_gnt_op,
    output logic              if_rvalid_op,
    output logic [WORD_W-1:0] if_rdata_op,
    input  logic              lsu_req_ip,
    input  logic              lsu_we_ip,
    input  logic [BE_W-1:0]   lsu_be_ip,
    input  logic [WORD_W-1:0] lsu_addr_ip,
    input  logic [WORD_W-1:0] lsu_wdata_ip,
    output logic              lsu_gnt_op,
    output logic              lsu_rvalid_op,
    output logic [WORD_W-1:0] lsu_rdata_op,
    output logic              dram_req_op,
    output logic              dram_we_op,
    output logic [BE_W-1:0]   dram_be_op,
    output logic [WORD_W-1:0] dram_addr_op,
    output logic [WORD_W-1:0] dram_wdata_op,
    input  logic              dram_gnt_ip,
    input  logic              dram_rvalid_ip,
    input  logic [WORD_W-1:0] dram_rdata_ip,
    output logic              timeout_err_op
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT) + 1;
    localparam int unsigned TIMER_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [TIMER_W-1:0]  TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);

    arb_state_e          state_q,  state_d;
    mem_owner_e          owner_q,  owner_d;
    dram_req_t           dreq_q,   dreq_d;
    logic                squash_q, squash_d;
    logic                err_q,    err_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [TIMER_W-1:0]  timer_q,  timer_d;
    logic [TIMER_W-1:0]  timer_inc;
    logic                if_wins;

    // IF only beats a simultaneous LSU request once it has been starved long enough.
    assign if_wins   = if_req_ip && (!lsu_req_ip || (starve_q == STARVE_MAX));
    assign timer_inc = timer_q + TIMER_W'(1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement leaves one unassigned and infers a latch.
        state_d       = state_q;
        owner_d       = owner_q;
        dreq_d        = dreq_q;
        squash_d      = squash_q;
        err_d         = err_q;
        timer_d       = timer_q;
        if_gnt_op     = 1'b0;
        lsu_gnt_op    = 1'b0;
        if_rvalid_op  = 1'b0;
        lsu_rvalid_op = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // Grants are gated by rst_n so they stay low while reset is held.
                if (rst_n && mem_en && (if_req_ip || lsu_req_ip)) begin
                    state_d = ARB_REQ;
                    timer_d = '0;
                    if (if_wins) begin
                        owner_d   = OWNER_IF;
                        if_gnt_op = 1'b1;
                        squash_d  = flush_en_ip;
                        dreq_d    = '{we: 1'b0, be: '1, addr: if_addr_ip, wdata: '0};
                    end else begin
                        owner_d    = OWNER_LSU;
                        lsu_gnt_op = 1'b1;
                        squash_d   = 1'b0;
                        dreq_d     = '{we: lsu_we_ip, be: lsu_be_ip,
                                       addr: lsu_addr_ip, wdata: lsu_wdata_ip};
                    end
                end
            end

            ARB_REQ, ARB_RESP: begin
                if ((owner_q == OWNER_IF) && flush_en_ip) begin
                    squash_d = 1'b1;
                end
                if ((state_q == ARB_RESP) && dram_rvalid_ip) begin
                    state_d  = ARB_IDLE;
                    squash_d = 1'b0;
                    if (owner_q == OWNER_LSU) begin
                        lsu_rvalid_op = 1'b1;
                    end else begin
                        if_rvalid_op = !(squash_q || flush_en_ip);
                    end
                end else if (timer_inc == TIMER_MAX) begin
                    state_d  = ARB_IDLE;
                    squash_d = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    timer_d = timer_inc;
                    if ((state_q == ARB_REQ) && dram_gnt_ip) begin
                        state_d = ARB_RESP;
                    end
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req_ip || if_gnt_op) begin
            starve_d = '0;
        end else if (lsu_gnt_op && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWNER_IF;
            dreq_q   <= '0;
            squash_q <= 1'b0;
            err_q    <= 1'b0;
            starve_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            dreq_q   <= dreq_d;
            squash_q <= squash_d;
            err_q    <= err_d;
            starve_q <= starve_d;
            timer_q  <= timer_d;
        end
    end

    assign dram_req_op    = (state_q == ARB_REQ);
    assign dram_we_op     = dreq_q.we;
    assign dram_be_op     = dreq_q.be;
    assign dram_addr_op   = dreq_q.addr;
    assign dram_wdata_op  = dreq_q.wdata;
    assign if_rdata_op    = dram_rdata_ip;
    assign lsu_rdata_op   = dram_rdata_ip;
    assign timeout_err_op = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: inputs change on the falling
// edge, outputs are sampled 2 ns later, well away from the rising edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_en;
    logic        flush_en_ip;
    logic        if_req_ip;
    logic [31:0] if_addr_ip;
    logic        if_gnt_op, if_rvalid_op;
    logic [31:0] if_rdata_op;
    logic        lsu_req_ip, lsu_we_ip;
    logic [3:0]  lsu_be_ip;
    logic [31:0] lsu_addr_ip, lsu_wdata_ip;
    logic        lsu_gnt_op, lsu_rvalid_op;
    logic [31:0] lsu_rdata_op;
    logic        dram_req_op, dram_we_op;
    logic [3:0]  dram_be_op;
    logic [31:0] dram_addr_op, dram_wdata_op;
    logic        dram_gnt_ip, dram_rvalid_ip;
    logic [31:0] dram_rdata_ip;
    logic        timeout_err_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_en         (mem_en),
        .flush_en_ip    (flush_en_ip),
        .if_req_ip      (if_req_ip),
        .if_addr_ip     (if_addr_ip),
        .if_gnt_op      (if_gnt_op),
        .if_rvalid_op   (if_rvalid_op),
        .if_rdata_op    (if_rdata_op),
        .lsu_req_ip     (lsu_req_ip),
        .lsu_we_ip      (lsu_we_ip),
        .lsu_be_ip      (lsu_be_ip),
        .lsu_addr_ip    (lsu_addr_ip),
        .lsu_wdata_ip   (lsu_wdata_ip),
        .lsu_gnt_op     (lsu_gnt_op),
        .lsu_rvalid_op  (lsu_rvalid_op),
        .lsu_rdata_op   (lsu_rdata_op),
        .dram_req_op    (dram_req_op),
        .dram_we_op     (dram_we_op),
        .dram_be_op     (dram_be_op),
        .dram_addr_op   (dram_addr_op),
        .dram_wdata_op  (dram_wdata_op),
        .dram_gnt_ip    (dram_gnt_ip),
        .dram_rvalid_ip (dram_rvalid_ip),
        .dram_rdata_ip  (dram_rdata_ip),
        .timeout_err_op (timeout_err_op)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called in the grant cycle: DRAM grants at once, responds the next cycle.
    task automatic finish_txn(input string tag, input logic [31:0] rdata,
                              input logic exp_if, input logic exp_lsu, input logic keep_if);
        @(negedge clk);
        lsu_req_ip  = 1'b0;
        flush_en_ip = 1'b0;
        if (!keep_if) if_req_ip = 1'b0;
        dram_gnt_ip = 1'b1;
        #2 check({tag, " dram_req"}, dram_req_op, 1'b1);
        @(negedge clk);
        dram_gnt_ip    = 1'b0;
        dram_rvalid_ip = 1'b1;
        dram_rdata_ip  = rdata;
        #2;
        check({tag, " dram_req drop"}, dram_req_op, 1'b0);
        check({tag, " if_rvalid"}, if_rvalid_op, exp_if);
        check({tag, " lsu_rvalid"}, lsu_rvalid_op, exp_lsu);
        if (exp_if) check({tag, " if_rdata"}, if_rdata_op, rdata);
        @(negedge clk);
        dram_rvalid_ip = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lsu_cnt;
        logic got_if, pend;

        rst_n = 1'b0; mem_en = 1'b1; flush_en_ip = 1'b0;
        if_req_ip = 1'b0; if_addr_ip = '0;
        lsu_req_ip = 1'b0; lsu_we_ip = 1'b0; lsu_be_ip = '0; lsu_addr_ip = '0; lsu_wdata_ip = '0;
        dram_gnt_ip = 1'b0; dram_rvalid_ip = 1'b0; dram_rdata_ip = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst dram_req", dram_req_op, 1'b0);
        check("rst dram_we", dram_we_op, 1'b0);
        check("rst dram_be", dram_be_op, 4'h0);
        check("rst dram_addr", dram_addr_op, 32'h0);
        check("rst dram_wdata", dram_wdata_op, 32'h0);
        check("rst gnts", {if_gnt_op, lsu_gnt_op}, 2'b00);
        check("rst rvalids", {if_rvalid_op, lsu_rvalid_op}, 2'b00);
        check("rst timeout_err", timeout_err_op, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lone IF read, minimum latency
        @(negedge clk);
        if_req_ip = 1'b1; if_addr_ip = 32'h10;
        #2;
        check("if0 if_gnt", if_gnt_op, 1'b1);
        check("if0 lsu_gnt", lsu_gnt_op, 1'b0);
        @(negedge clk);
        if_req_ip = 1'b0; dram_gnt_ip = 1'b1;
        #2;
        check("if0 dram_req", dram_req_op, 1'b1);
        check("if0 dram_addr", dram_addr_op, 32'h10);
        check("if0 dram_we", dram_we_op, 1'b0);
        check("if0 gnt single pulse", if_gnt_op, 1'b0);
        @(negedge clk);
        dram_gnt_ip = 1'b0; dram_rvalid_ip = 1'b1; dram_rdata_ip = 32'h0050_0093;
        #2;
        check("if0 dram_req drop", dram_req_op, 1'b0);
        check("if0 if_rvalid", if_rvalid_op, 1'b1);
        check("if0 if_rdata", if_rdata_op, 32'h0050_0093);
        check("if0 lsu_rvalid", lsu_rvalid_op, 1'b0);
        @(negedge clk);
        dram_rvalid_ip = 1'b0;
        #2 check("if0 rvalid single pulse", if_rvalid_op, 1'b0);

        // Stray DRAM response while idle is ignored
        dram_rvalid_ip = 1'b1;
        #2 check("stray idle rvalid", {if_rvalid_op, lsu_rvalid_op}, 2'b00);
        @(negedge clk);
        dram_rvalid_ip = 1'b0;

        // Simultaneous IF read and LSU store: LSU first, IF in the next IDLE
        if_req_ip = 1'b1; if_addr_ip = 32'h14;
        lsu_req_ip = 1'b1; lsu_we_ip = 1'b1; lsu_be_ip = 4'hF;
        lsu_addr_ip = 32'h200; lsu_wdata_ip = 32'hDEAD_BEEF;
        #2;
        check("st lsu_gnt", lsu_gnt_op, 1'b1);
        check("st if_gnt", if_gnt_op, 1'b0);
        @(negedge clk);
        lsu_req_ip = 1'b0;
        #2;
        check("st dram_we", dram_we_op, 1'b1);
        check("st dram_addr", dram_addr_op, 32'h200);
        check("st dram_wdata", dram_wdata_op, 32'hDEAD_BEEF);
        check("st dram_be", dram_be_op, 4'hF);
        check("st if waits", if_gnt_op, 1'b0);
        // Already one cycle into REQ; hand the remaining phases to finish_txn.
        finish_txn("st", 32'h0, 1'b0, 1'b1, 1'b1);
        #2 check("st if_gnt next idle", if_gnt_op, 1'b1);
        finish_txn("st_if", 32'h0000_0013, 1'b1, 1'b0, 1'b0);

        // Starvation guard: IF wins after exactly STARVE_LIMIT LSU grants
        if_req_ip = 1'b1; if_addr_ip = 32'h18;
        lsu_req_ip = 1'b1; lsu_we_ip = 1'b0; lsu_addr_ip = 32'h300;
        lsu_cnt = 0; got_if = 1'b0; pend = 1'b0;
        for (int i = 0; i < 40 && !got_if; i++) begin
            if (i > 0) @(negedge clk);
            dram_rvalid_ip = pend;
            dram_gnt_ip    = dram_req_op;
            pend           = dram_req_op;
            #2;
            if (if_gnt_op) got_if = 1'b1;
            else if (lsu_gnt_op) lsu_cnt++;
        end
        dram_rvalid_ip = 1'b0;
        dram_gnt_ip    = 1'b0;
        check("starve if granted", got_if, 1'b1);
        check("starve lsu grants before if", lsu_cnt, 32'd4);
        check("starve dram_addr held", dram_addr_op, 32'h300);
        finish_txn("starve_if", 32'h0000_0033, 1'b1, 1'b0, 1'b0);

        // Flush during RESP squashes the IF response
        if_req_ip = 1'b1; if_addr_ip = 32'h20;
        #2 check("fl if_gnt", if_gnt_op, 1'b1);
        @(negedge clk);
        if_req_ip = 1'b0; dram_gnt_ip = 1'b1;
        @(negedge clk);
        dram_gnt_ip = 1'b0; flush_en_ip = 1'b1;
        @(negedge clk);
        flush_en_ip = 1'b0; dram_rvalid_ip = 1'b1; dram_rdata_ip = 32'hBAD0_0001;
        #2;
        check("fl if_rvalid squashed", if_rvalid_op, 1'b0);
        check("fl dram_req", dram_req_op, 1'b0);
        @(negedge clk);
        dram_rvalid_ip = 1'b0;
        if_req_ip = 1'b1; if_addr_ip = 32'h24;
        #2 check("fl next if_gnt", if_gnt_op, 1'b1);
        finish_txn("fl_next", 32'h0000_0113, 1'b1, 1'b0, 1'b0);

        // Flush coincident with IF grant squashes; with LSU it has no effect
        if_req_ip = 1'b1; if_addr_ip = 32'h28; flush_en_ip = 1'b1;
        #2 check("flg if_gnt", if_gnt_op, 1'b1);
        finish_txn("flg_if", 32'hBAD0_0002, 1'b0, 1'b0, 1'b0);
        lsu_req_ip = 1'b1; lsu_we_ip = 1'b0; lsu_addr_ip = 32'h400; flush_en_ip = 1'b1;
        #2 check("flg lsu_gnt", lsu_gnt_op, 1'b1);
        finish_txn("flg_lsu", 32'h1234_5678, 1'b0, 1'b1, 1'b0);

        // mem_en low blocks new requests but not an in-flight one
        mem_en = 1'b0; if_req_ip = 1'b1; if_addr_ip = 32'h30;
        #2 check("men if_gnt blocked", if_gnt_op, 1'b0);
        @(negedge clk);
        #2 check("men no dram_req", dram_req_op, 1'b0);
        mem_en = 1'b1;
        #2 check("men if_gnt", if_gnt_op, 1'b1);
        @(negedge clk);
        mem_en = 1'b0; if_req_ip = 1'b0; dram_gnt_ip = 1'b1;
        #2 check("men inflight dram_req", dram_req_op, 1'b1);
        @(negedge clk);
        dram_gnt_ip = 1'b0; dram_rvalid_ip = 1'b1; dram_rdata_ip = 32'h0000_0213;
        #2 check("men inflight if_rvalid", if_rvalid_op, 1'b1);
        @(negedge clk);
        dram_rvalid_ip = 1'b0; mem_en = 1'b1;

        // Timeout: DRAM never grants
        lsu_req_ip = 1'b1; lsu_we_ip = 1'b1; lsu_addr_ip = 32'h40; lsu_wdata_ip = 32'h5;
        #2 check("to lsu_gnt", lsu_gnt_op, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            lsu_req_ip = 1'b0;
        end
        #2;
        check("to last cycle dram_req", dram_req_op, 1'b1);
        check("to last cycle err", timeout_err_op, 1'b0);
        @(negedge clk);
        dram_rvalid_ip = 1'b1;
        #2;
        check("to err set", timeout_err_op, 1'b1);
        check("to back to idle", dram_req_op, 1'b0);
        check("to no rvalid", lsu_rvalid_op, 1'b0);
        @(negedge clk);
        dram_rvalid_ip = 1'b0;
        if_req_ip = 1'b1; if_addr_ip = 32'h50;
        #2 check("to recover if_gnt", if_gnt_op, 1'b1);
        finish_txn("to_recover", 32'h0000_0313, 1'b1, 1'b0, 1'b0);
        check("to err sticky", timeout_err_op, 1'b1);

        // Asynchronous reset in RESP, stray response after release
        if_req_ip = 1'b1; if_addr_ip = 32'h60;
        @(negedge clk);
        if_req_ip = 1'b0; dram_gnt_ip = 1'b1;
        @(negedge clk);
        dram_gnt_ip = 1'b0;
        #2 rst_n = 1'b0;
        dram_rvalid_ip = 1'b1;
        #1;
        check("arst dram_req", dram_req_op, 1'b0);
        check("arst dram_addr", dram_addr_op, 32'h0);
        check("arst dram_be", dram_be_op, 4'h0);
        check("arst timeout_err", timeout_err_op, 1'b0);
        check("arst if_rvalid", if_rvalid_op, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #2 check("arst late rvalid ignored", {if_rvalid_op, lsu_rvalid_op}, 2'b00);
        @(negedge clk);
        dram_rvalid_ip = 1'b0;
        #2 check("arst stays idle", dram_req_op, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4; maximum consecutive LSU grants while an IF request waits.
REQ-002 Parameter TIMEOUT_CYCLES, default 16; maximum cycles a DRAM transaction may remain outstanding.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 mem_en  in  1  global enable; when low, no new DRAM request issued.
REQ-006 flush_en_ip  in  1  squash pending/outstanding IF response.
REQ-007 if_req_ip / if_addr_ip  in  1/32  instruction fetch request and word address.
REQ-008 if_gnt_op / if_rvalid_op / if_rdata_op  out  1/1/32  IF accept pulse, response valid pulse, instruction data.
REQ-009 lsu_req_ip / lsu_we_ip / lsu_be_ip / lsu_addr_ip / lsu_wdata_ip  in  1/1/4/32/32  data request, write enable, byte enables, address, store data.
REQ-010 lsu_gnt_op / lsu_rvalid_op / lsu_rdata_op  out  1/1/32  LSU accept pulse, response valid pulse, load data.
REQ-011 dram_req_op / dram_we_op / dram_be_op / dram_addr_op / dram_wdata_op  out  1/1/4/32/32  single DRAM port request.
REQ-012 dram_gnt_ip / dram_rvalid_ip / dram_rdata_ip  in  1/1/32  DRAM accept, response valid, read data.
REQ-013 timeout_err_op  out  1  sticky error flag.

Function
REQ-014 FSM states SHALL be IDLE, REQ (dram_req_op high, awaiting dram_gnt_ip), RESP (awaiting dram_rvalid_ip); one transaction outstanding at most.
REQ-015 IDLE -> REQ when mem_en=1 and any request is high; arbitration decided combinationally in IDLE and owner latched on the transition.
REQ-016 Priority: LSU over IF, except IF wins when starve counter equals STARVE_LIMIT.
REQ-017 Starve counter increments on each LSU grant while if_req_ip=1, clears on any IF grant or when if_req_ip=0, saturates at STARVE_LIMIT.
REQ-018 if_gnt_op / lsu_gnt_op SHALL pulse one cycle, same cycle as IDLE->REQ transition; request fields latched that cycle and held stable on dram_* until grant.
REQ-019 REQ -> RESP on dram_gnt_ip=1; dram_req_op deasserts the following cycle.
REQ-020 RESP -> IDLE on dram_rvalid_ip=1; owner's rvalid pulses that same cycle, rdata driven combinationally from dram_rdata_ip; writes also return rvalid (rdata don't-care).
REQ-021 Minimum request-to-response latency SHALL be 2 cycles (grant cycle + DRAM response cycle); back-to-back transactions allowed with IDLE for one cycle between.
REQ-022 flush_en_ip=1 while owner is IF in REQ or RESP SHALL set a squash bit; matching dram_rvalid_ip consumed without if_rvalid_op; squash clears on return to IDLE.
REQ-023 flush_en_ip SHALL NOT affect LSU transactions; flush coincident with IF grant squashes that transaction.
REQ-024 Timeout counter counts cycles in REQ/RESP; on reaching TIMEOUT_CYCLES, timeout_err_op sets (sticky), FSM returns to IDLE, no rvalid issued.
REQ-025 mem_en low SHALL not abort an in-flight transaction.
REQ-026 dram_rvalid_ip outside RESP SHALL be ignored.

Reset
REQ-027 On reset=0: FSM IDLE, all *_gnt_op, *_rvalid_op, dram_req_op, dram_we_op, timeout_err_op = 0; dram_addr_op, dram_wdata_op, dram_be_op = 0; counters and squash = 0.
REQ-028 Reset mid-transaction abandons it; late dram_rvalid_ip after reset release ignored per REQ-026.

Structure
REQ-029 Arbiter state enum and mem owner enum (OWNER_IF, OWNER_LSU) SHALL live in CORE_PKG alongside existing core typedefs.
REQ-030 Single module; no sub-module; starve and timeout counters sized $clog2(param)+1.

Verification
REQ-031 Lone IF read addr 0x10, DRAM gnt same cycle, rvalid next with 0x00500093 -> if_gnt pulse, if_rvalid pulse 2 cycles later, if_rdata=0x00500093.
REQ-032 IF and LSU store (addr 0x200, data 0xDEADBEEF, be 0xF) same cycle -> LSU granted first, dram_we_op=1; IF granted next IDLE.
REQ-033 IF held high, LSU requests every cycle -> IF granted after exactly 4 LSU grants.
REQ-034 IF read granted, flush_en_ip pulsed in RESP -> dram_rvalid consumed, if_rvalid_op stays 0, next request accepted normally.
REQ-035 Request issued, dram_gnt_ip held 0 for 16 cycles -> timeout_err_op=1, FSM IDLE, no rvalid; stays 1 until reset.
REQ-036 Reset asserted in RESP -> all outputs 0 asynchronously; stray dram_rvalid_ip after release produces no rvalid.
